beep_pattern_gen: RTL and testbench



---
 rtl/beep_pattern_gen.sv | 192 +++++++++++++++++++
 tb/tb_beep_pattern_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/beep_pattern_gen.sv
// beep_pattern_gen: plays a sequence of tone bursts on a buzzer pin.
// A one-cycle start latches burst count, on-time and off-time (in units of
// UNIT_CYC clocks). The block alternates ON (tone) and OFF (silence) phases,
// reports busy while playing, and pulses done after the last burst.
// beep_env drives an active buzzer; beep carries a square wave for a passive one.
module beep_pattern_gen #(
    parameter int UNIT_CYC = 50_000,
    parameter int TONE_DIV = 12_500
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [3:0] beep_cnt,
    input  logic [7:0] on_units,
    input  logic [7:0] off_units,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       beep_env,
    output logic       beep
);

    // Counter widths are kept at least 1 bit so a divider of 1 still elaborates.
    localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);
    localparam logic [UW-1:0] UNIT_ONE  = UW'(1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
    localparam logic [TW-1:0] TONE_ONE  = TW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    logic [1:0]    r_state;
    logic [UW-1:0] r_unit_cnt;
    logic [7:0]    r_tally;
    logic [TW-1:0] r_tone_cnt;
    logic [3:0]    r_remaining;
    logic [7:0]    r_on_units;
    logic [7:0]    r_off_units;
    logic          r_busy;
    logic          r_done;
    logic          r_env;
    logic          r_beep;

    logic          w_unit_last;
    logic          w_on_last;
    logic          w_off_last;
    logic          w_tone_last;
    logic          w_start_ok;
    logic [3:0]    w_rem_dec;

    // Terminal-count decodes and start qualification for the sequencer.
    always_comb begin
        w_unit_last = (r_unit_cnt == UNIT_LAST);
        w_on_last   = w_unit_last && (r_tally == (r_on_units - 8'd1));
        w_off_last  = w_unit_last && (r_tally == (r_off_units - 8'd1));
        w_tone_last = (r_tone_cnt == TONE_LAST);
        w_start_ok  = start && !abort && (beep_cnt != 4'd0) && (on_units != 8'd0);
        w_rem_dec   = r_remaining - 4'd1;
    end

    // Sequencer: phase state, duration counters and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_unit_cnt  <= '0;
            r_tally     <= 8'd0;
            r_tone_cnt  <= '0;
            r_remaining <= 4'd0;
            r_on_units  <= 8'd0;
            r_off_units <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_env       <= 1'b0;
            r_beep      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state     <= S_ON;
                        r_on_units  <= on_units;
                        r_off_units <= off_units;
                        r_remaining <= beep_cnt;
                        r_unit_cnt  <= '0;
                        r_tally     <= 8'd0;
                        r_tone_cnt  <= '0;
                        r_busy      <= 1'b1;
                        r_env       <= 1'b1;
                        r_beep      <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                        r_env  <= 1'b0;
                        r_beep <= 1'b0;
                    end
                end
                S_ON: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_unit_cnt  <= '0;
                        r_tally     <= 8'd0;
                        r_tone_cnt  <= '0;
                        r_remaining <= 4'd0;
                        r_busy      <= 1'b0;
                        r_env       <= 1'b0;
                        r_beep      <= 1'b0;
                    end else if (w_on_last) begin
                        // Burst finished: counters reload, tone phase restarts on next ON.
                        r_remaining <= w_rem_dec;
                        r_unit_cnt  <= '0;
                        r_tally     <= 8'd0;
                        r_tone_cnt  <= '0;
                        if (w_rem_dec == 4'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_env   <= 1'b0;
                            r_beep  <= 1'b0;
                        end else if (r_off_units == 8'd0) begin
                            r_state <= S_ON;
                            r_busy  <= 1'b1;
                            r_env   <= 1'b1;
                            r_beep  <= 1'b1;
                        end else begin
                            r_state <= S_OFF;
                            r_busy  <= 1'b1;
                            r_env   <= 1'b0;
                            r_beep  <= 1'b0;
                        end
                    end else begin
                        if (w_unit_last) begin
                            r_unit_cnt <= '0;
                            r_tally    <= r_tally + 8'd1;
                        end else begin
                            r_unit_cnt <= r_unit_cnt + UNIT_ONE;
                        end
                        if (w_tone_last) begin
                            r_tone_cnt <= '0;
                            r_beep     <= ~r_beep;
                        end else begin
                            r_tone_cnt <= r_tone_cnt + TONE_ONE;
                        end
                    end
                end
                S_OFF: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_unit_cnt  <= '0;
                        r_tally     <= 8'd0;
                        r_tone_cnt  <= '0;
                        r_remaining <= 4'd0;
                        r_busy      <= 1'b0;
                        r_env       <= 1'b0;
                        r_beep      <= 1'b0;
                    end else if (w_off_last) begin
                        r_state    <= S_ON;
                        r_unit_cnt <= '0;
                        r_tally    <= 8'd0;
                        r_tone_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_env      <= 1'b1;
                        r_beep     <= 1'b1;
                    end else if (w_unit_last) begin
                        r_unit_cnt <= '0;
                        r_tally    <= r_tally + 8'd1;
                    end else begin
                        r_unit_cnt <= r_unit_cnt + UNIT_ONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_unit_cnt  <= '0;
                    r_tally     <= 8'd0;
                    r_tone_cnt  <= '0;
                    r_remaining <= 4'd0;
                    r_busy      <= 1'b0;
                    r_env       <= 1'b0;
                    r_beep      <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign beep_env = r_env;
    assign beep     = r_beep;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Scoreboard bench for beep_pattern_gen with UNIT_CYC=4, TONE_DIV=2.
// Each stimulus cycle pushes the hand-computed expected outputs for the next
// cycle, tagged with that cycle number; a monitor on the falling edge pops and
// compares every entry that falls due.
module tb_beep_pattern_gen;

    logic       sys_clk;
    logic       sys_rst;
    logic       start;
    logic [3:0] beep_cnt;
    logic [7:0] on_units;
    logic [7:0] off_units;
    logic       abort;
    logic       busy;
    logic       done;
    logic       beep_env;
    logic       beep;

    beep_pattern_gen #(.UNIT_CYC(4), .TONE_DIV(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .beep_cnt  (beep_cnt),
        .on_units  (on_units),
        .off_units (off_units),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .beep_env  (beep_env),
        .beep      (beep)
    );

    typedef struct {
        int         cyc;
        logic [3:0] exp;
        string      name;
    } ent_t;

    ent_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Cycle counter: value N during the cycle following the N-th rising edge.
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic string sig_name(input int k);
        case (k)
            3: return "busy";
            2: return "done";
            1: return "beep_env";
            default: return "beep";
        endcase
    endfunction

    // Monitor: compare every scoreboard entry whose cycle has come.
    always @(negedge sys_clk) begin
        logic [3:0] act;
        ent_t       e;
        act = {busy, done, beep_env, beep};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_checks++;
                n_err++;
                $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if (act[k] !== e.exp[k]) begin
                        n_err++;
                        $display("FAIL %s %s cyc=%0d got=%b want=%b",
                                 e.name, sig_name(k), e.cyc, act[k], e.exp[k]);
                    end
                end
            end
        end
    end

    function automatic logic bit_at(input string s, input int i);
        return (s[i] == 8'h31);
    endfunction

    // One directed scenario. Index i of each pattern string is the expected
    // output in the cycle after stimulus cycle i. Optional second start at
    // st2, abort at ab, synchronous reset at rs (-1 = unused).
    task automatic play(input string name, input logic s0,
                        input logic [3:0] c0, input logic [7:0] o0, input logic [7:0] f0,
                        input int st2, input logic [3:0] c2, input logic [7:0] o2,
                        input logic [7:0] f2, input int ab, input int rs,
                        input string pb, input string pd, input string pe, input string pp);
        ent_t e;
        for (int i = 0; i < pb.len(); i++) begin
            start     = (s0 && i == 0) || (i == st2);
            beep_cnt  = 4'd0;
            on_units  = 8'd0;
            off_units = 8'd0;
            if (i == st2) begin
                beep_cnt = c2; on_units = o2; off_units = f2;
            end else if (i == 0) begin
                beep_cnt = c0; on_units = o0; off_units = f0;
            end
            abort   = (i == ab);
            sys_rst = (i == rs);
            e.cyc  = cyc + 1;
            e.exp  = {bit_at(pb, i), bit_at(pd, i), bit_at(pe, i), bit_at(pp, i)};
            e.name = name;
            sb.push_back(e);
            @(posedge sys_clk);
            #1;
        end
        start = 1'b0; abort = 1'b0; sys_rst = 1'b0;
        beep_cnt = 4'd0; on_units = 8'd0; off_units = 8'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        ent_t e;
        int   wait_cyc;
        sys_rst = 1'b1; start = 1'b0; abort = 1'b0;
        beep_cnt = 4'd0; on_units = 8'd0; off_units = 8'd0;
        @(posedge sys_clk);
        #1;
        // Reset held: outputs must already read 0 after the first edge.
        for (int i = 0; i < 2; i++) begin
            e.cyc = cyc; e.exp = 4'b0000; e.name = "reset_hold";
            sb.push_back(e);
            @(posedge sys_clk);
            #1;
        end
        sys_rst = 1'b0;

        play("idle50", 1'b0, 4'd0, 8'd0, 8'd0, -1, 4'd0, 8'd0, 8'd0, -1, -1,
             "00000000000000000000000000000000000000000000000000",
             "00000000000000000000000000000000000000000000000000",
             "00000000000000000000000000000000000000000000000000",
             "00000000000000000000000000000000000000000000000000");

        play("c1_on2_off3", 1'b1, 4'd1, 8'd2, 8'd3, -1, 4'd0, 8'd0, 8'd0, -1, -1,
             "111111110000", "000000001000", "111111110000", "110011000000");

        play("c3_on1_off2", 1'b1, 4'd3, 8'd1, 8'd2, -1, 4'd0, 8'd0, 8'd0, -1, -1,
             "1111111111111111111111111111000",
             "0000000000000000000000000000100",
             "1111000000001111000000001111000",
             "1100000000001100000000001100000");

        play("c2_on1_off0", 1'b1, 4'd2, 8'd1, 8'd0, -1, 4'd0, 8'd0, 8'd0, -1, -1,
             "11111111000", "00000000100", "11111111000", "11001100000");

        play("start_busy_ign", 1'b1, 4'd1, 8'd2, 8'd3, 3, 4'd5, 8'd1, 8'd1, -1, -1,
             "111111110000", "000000001000", "111111110000", "110011000000");

        play("start_on_done", 1'b1, 4'd1, 8'd2, 8'd3, 9, 4'd1, 8'd1, 8'd0, -1, -1,
             "111111110111100", "000000001000010", "111111110111100", "110011000110000");

        play("cnt0_ignored", 1'b1, 4'd0, 8'd2, 8'd1, -1, 4'd0, 8'd0, 8'd0, -1, -1,
             "0000000000", "0000000000", "0000000000", "0000000000");

        play("on0_ignored", 1'b1, 4'd2, 8'd0, 8'd1, -1, 4'd0, 8'd0, 8'd0, -1, -1,
             "0000000000", "0000000000", "0000000000", "0000000000");

        play("abort_idle_start", 1'b1, 4'd2, 8'd1, 8'd1, -1, 4'd0, 8'd0, 8'd0, 0, -1,
             "000000", "000000", "000000", "000000");

        play("abort_off3", 1'b1, 4'd2, 8'd1, 8'd3, 7, 4'd1, 8'd1, 8'd0, 7, -1,
             "11111110000000", "00000000000000", "11110000000000", "11000000000000");

        play("rst_off3", 1'b1, 4'd2, 8'd1, 8'd3, -1, 4'd0, 8'd0, 8'd0, -1, 7,
             "11111110000000", "00000000000000", "11110000000000", "11000000000000");

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge sys_clk);
            wait_cyc++;
        end
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
